// File: rtl/io_input_fifo_pkg.sv
// Shared types for the buffered CPU I/O ports: handshake FSM states and byte width.
package io_input_fifo_pkg;

  localparam int WORD_SIZE_DEFAULT = 16;
  localparam int BYTE_W            = 8;

  typedef enum logic [1:0] {
    IO_WAITREQ  = 2'd0,
    IO_DOWORK   = 2'd1,
    IO_WAITACK  = 2'd2,
    IO_WAITDATA = 2'd3
  } io_state_t;

endpackage

// File: rtl/io_input_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       areset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/io_input_fifo.sv
// Buffered CPU input port: queues host bytes and delivers extended words over a
// four-phase req/ack handshake, returning EOF_VALUE once the stream has drained.
module io_input_fifo
  import io_input_fifo_pkg::*;
#(
  parameter int                   WORD_SIZE   = WORD_SIZE_DEFAULT,
  parameter int                   DEPTH       = 8,
  parameter bit                   SIGN_EXTEND = 1'b0,
  parameter logic [WORD_SIZE-1:0] EOF_VALUE   = '1
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [7:0]             src_data,
  input  logic                   src_eof,
  input  logic                   req,
  output logic                   ack,
  output logic [WORD_SIZE-1:0]   data,
  output logic                   eof,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned WU = WORD_SIZE;

  io_state_t             state;
  io_state_t             state_next;
  logic                  eof_seen;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  avail;
  logic [BYTE_W-1:0]     head;
  logic [WORD_SIZE-1:0]  ext;

  assign src_ready = !full && !eof_seen;
  assign push      = src_valid && src_ready;
  assign pop       = (state == IO_DOWORK) && !empty;
  assign avail     = !empty || eof_seen;
  assign ack       = (state == IO_WAITACK);

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .areset_n (areset_n),
    .push     (push),
    .wdata    (src_data),
    .pop      (pop),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // Loop form keeps WORD_SIZE == 8 legal (no zero-width replication).
  always_comb begin
    ext = '0;
    ext[BYTE_W-1:0] = head;
    for (int unsigned i = BYTE_W; i < WU; i++) begin
      ext[i] = SIGN_EXTEND && head[BYTE_W-1];
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= IO_WAITREQ;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IO_WAITREQ:  if (req) state_next = avail ? IO_DOWORK : IO_WAITDATA;
      IO_WAITDATA: if (avail) state_next = IO_DOWORK;
      IO_DOWORK:   state_next = IO_WAITACK;
      IO_WAITACK:  if (!req) state_next = IO_WAITREQ;
      default:     state_next = IO_WAITREQ;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      eof_seen <= 1'b0;
      eof      <= 1'b0;
      data     <= '0;
    end else begin
      if (src_eof) eof_seen <= 1'b1;
      if (state == IO_DOWORK) begin
        if (!empty) begin
          data <= ext;
        end else begin
          data <= EOF_VALUE;
          eof  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_input_fifo.sv
// Bench for io_input_fifo: sign- and zero-extending instances share stimulus and
// are checked against a queue-based model of the byte stream.
module tb_io_input_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = '0;
  logic        src_eof = 1'b0;
  logic        req = 1'b0;

  logic        src_ready_s, src_ready_z;
  logic        ack_s, ack_z;
  logic [15:0] data_s, data_z;
  logic        eof_s, eof_z;
  logic [2:0]  level_s, level_z;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] q[$];
  bit         m_eof_seen = 1'b0;
  bit         m_eof      = 1'b0;

  always #5 clk = ~clk;

  io_input_fifo #(
    .WORD_SIZE   (16),
    .DEPTH       (DEPTH),
    .SIGN_EXTEND (1'b1),
    .EOF_VALUE   (16'hFFFF)
  ) dut_s (
    .clk       (clk),
    .areset_n  (areset_n),
    .src_valid (src_valid),
    .src_ready (src_ready_s),
    .src_data  (src_data),
    .src_eof   (src_eof),
    .req       (req),
    .ack       (ack_s),
    .data      (data_s),
    .eof       (eof_s),
    .level     (level_s)
  );

  io_input_fifo #(
    .WORD_SIZE   (16),
    .DEPTH       (DEPTH),
    .SIGN_EXTEND (1'b0),
    .EOF_VALUE   (16'hFFFF)
  ) dut_z (
    .clk       (clk),
    .areset_n  (areset_n),
    .src_valid (src_valid),
    .src_ready (src_ready_z),
    .src_data  (src_data),
    .src_eof   (src_eof),
    .req       (req),
    .ack       (ack_z),
    .data      (data_z),
    .eof       (eof_z),
    .level     (level_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    req = 1'b0; src_valid = 1'b0; src_eof = 1'b0;
    q.delete();
    m_eof_seen = 1'b0;
    m_eof = 1'b0;
    step();
    step();
    areset_n = 1'b1;
    step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit rdy;
    rdy = (q.size() < DEPTH) && !m_eof_seen;
    src_valid = 1'b1;
    src_data  = b;
    check("src_ready_s", src_ready_s, rdy);
    check("src_ready_z", src_ready_z, rdy);
    step();
    src_valid = 1'b0;
    if (rdy) q.push_back(b);
    check("push_level", level_s, q.size());
  endtask

  // Caller guarantees data is available (queue non-empty or stream ended).
  task automatic read_word(input string tag);
    logic [7:0]  b;
    logic [15:0] es, ez;
    req = 1'b1;
    step();
    check({tag, "_ack_early"}, ack_s, 0);
    step();
    if (q.size() != 0) begin
      b  = q.pop_front();
      es = {{8{b[7]}}, b};
      ez = {8'h00, b};
    end else begin
      es = 16'hFFFF;
      ez = 16'hFFFF;
      m_eof = 1'b1;
    end
    check({tag, "_ack"}, {ack_s, ack_z}, 2'b11);
    check({tag, "_data_s"}, data_s, es);
    check({tag, "_data_z"}, data_z, ez);
    check({tag, "_eof"}, {eof_s, eof_z}, {m_eof, m_eof});
    check({tag, "_level"}, level_s, q.size());
    req = 1'b0;
    step();
    check({tag, "_ack_fall"}, ack_s, 0);
  endtask

  initial begin
    logic [7:0] b;

    // Reset values
    areset_n = 1'b0;
    #2;
    check("rst_ack", {ack_s, ack_z}, 0);
    check("rst_data", data_s, 0);
    check("rst_eof", eof_s, 0);
    check("rst_level", level_s, 0);
    do_reset();
    check("rst_src_ready", src_ready_s, 1);

    // Request on empty FIFO waits, then a push completes it two edges later
    req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("waitdata_ack", ack_s, 0);
    push_byte(8'h41);
    check("waitdata_ack_p0", ack_s, 0);
    step();
    check("waitdata_ack_p1", ack_s, 0);
    step();
    void'(q.pop_front());
    check("waitdata_ack_p2", ack_s, 1);
    check("waitdata_data", data_s, 16'h0041);
    check("waitdata_level", level_s, 0);
    req = 1'b0;
    step();
    check("waitdata_ack_fall", ack_s, 0);

    // Extension: 0x80 sign- vs zero-extended
    push_byte(8'h80);
    read_word("ext80");

    // Fill past capacity, then drain in order; second fill exercises wrap
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    check("full_level", level_s, DEPTH);
    for (int i = 0; i < 4; i++) read_word("drain1");
    for (int i = 0; i < 4; i++) push_byte(8'(8'hF0 + i));
    for (int i = 0; i < 4; i++) read_word("drain2");

    // Simultaneous push and pop at level 2
    push_byte(8'hA1);
    push_byte(8'hB2);
    req = 1'b1;
    step();
    src_valid = 1'b1;
    src_data  = 8'hC3;
    step();
    src_valid = 1'b0;
    b = q.pop_front();
    q.push_back(8'hC3);
    check("pp_level", level_s, 2);
    check("pp_data", data_z, {8'h00, b});
    req = 1'b0;
    step();
    read_word("pp_b");
    read_word("pp_c");

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      if (q.size() == 0 || $urandom_range(0, 1) == 0) push_byte(8'($urandom));
      else read_word("rand");
    end
    while (q.size() != 0) read_word("rand_drain");

    // End of stream: the byte pushed alongside src_eof is kept, then sentinels
    do_reset();
    src_eof = 1'b1;
    push_byte(8'h10);
    src_eof = 1'b0;
    m_eof_seen = 1'b1;
    check("eof_src_ready", src_ready_s, 0);
    push_byte(8'h22);
    read_word("eof_byte");
    read_word("eof_sent1");
    read_word("eof_sent2");

    // Asynchronous reset during WAITACK
    do_reset();
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'hFE);
    req = 1'b1;
    step();
    step();
    check("ar_ack_before", ack_s, 1);
    areset_n = 1'b0;
    #1;
    check("ar_ack", {ack_s, ack_z}, 0);
    check("ar_level", level_s, 0);
    check("ar_data", {data_s, data_z}, 0);
    check("ar_eof", eof_s, 0);
    q.delete();
    req = 1'b0;
    step();
    areset_n = 1'b1;
    step();
    req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("ar_waitdata_ack", ack_s, 0);
    check("ar_waitdata_level", level_s, 0);
    req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
